// File: rtl/mips_pkg.sv
// Shared MIPS32 definitions: ALU func codes, R-type funct values, opcode,
// datapath widths and the R-type sequencer state encoding.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned FUNC_W  = 4;
    localparam int unsigned OP_W    = 6;

    // ALU operation select codes
    localparam logic [FUNC_W-1:0] ALU_AND = 4'd0;
    localparam logic [FUNC_W-1:0] ALU_OR  = 4'd1;
    localparam logic [FUNC_W-1:0] ALU_ADD = 4'd2;
    localparam logic [FUNC_W-1:0] ALU_SUB = 4'd6;
    localparam logic [FUNC_W-1:0] ALU_SLT = 4'd7;
    localparam logic [FUNC_W-1:0] ALU_NOR = 4'd12;

    // R-type funct field values
    localparam logic [OP_W-1:0] F_ADD  = 6'h20;
    localparam logic [OP_W-1:0] F_ADDU = 6'h21;
    localparam logic [OP_W-1:0] F_SUB  = 6'h22;
    localparam logic [OP_W-1:0] F_SUBU = 6'h23;
    localparam logic [OP_W-1:0] F_AND  = 6'h24;
    localparam logic [OP_W-1:0] F_OR   = 6'h25;
    localparam logic [OP_W-1:0] F_NOR  = 6'h27;
    localparam logic [OP_W-1:0] F_SLT  = 6'h2A;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

endpackage

// File: rtl/rtype_decoder.sv
// Combinational R-type decoder: splits the instruction into register fields
// and maps funct onto an ALU func code; legal is low for anything that is
// not a supported R-type operation.
// Ports: instr (in, 32) -> rs, rt, rd (5 each), func (4), legal (1).
module rtype_decoder
    import mips_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic [REG_AW-1:0]  rs,
    output logic [REG_AW-1:0]  rt,
    output logic [REG_AW-1:0]  rd,
    output logic [FUNC_W-1:0]  func,
    output logic               legal
);

    // shamt plays no part in the supported operations
    logic unused_shamt;
    assign unused_shamt = ^instr[10:6];

    // Field extraction and funct lookup
    always_comb begin
        rs    = instr[25:21];
        rt    = instr[20:16];
        rd    = instr[15:11];
        func  = ALU_AND;
        legal = 1'b0;
        if (instr[31:26] == OP_RTYPE) begin
            legal = 1'b1;
            case (instr[5:0])
                F_ADD, F_ADDU: func = ALU_ADD;
                F_SUB, F_SUBU: func = ALU_SUB;
                F_AND:         func = ALU_AND;
                F_OR:          func = ALU_OR;
                F_NOR:         func = ALU_NOR;
                F_SLT:         func = ALU_SLT;
                default:       legal = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/rtype_sequencer.sv
// Multi-cycle controller running one R-type instruction at a time through
// DECODE, EXEC and WB on the regfile + ALU datapath.
// Ports: clk, rst_n; instr_valid/instr_ready/instr handshake; alu_zero from
// the ALU; read_address1/2, write_address, func, write_enable to the
// datapath; busy, done, zero_flag, illegal, retired_count status.
module rtype_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               alu_zero,
    output logic [REG_AW-1:0]  read_address1,
    output logic [REG_AW-1:0]  read_address2,
    output logic [REG_AW-1:0]  write_address,
    output logic [FUNC_W-1:0]  func,
    output logic               write_enable,
    output logic               busy,
    output logic               done,
    output logic               zero_flag,
    output logic               illegal,
    output logic [COUNT_W-1:0] retired_count
);

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 zero_q, zero_d;

    logic                 ready_d, busy_d, we_d, done_d, illegal_d, zf_d;
    logic [REG_AW-1:0]    ra1_d, ra2_d, wa_d;
    logic [FUNC_W-1:0]    func_d;
    logic [COUNT_W-1:0]   cnt_d;

    logic [INSTR_W-1:0]   dec_in;
    logic [REG_AW-1:0]    dec_rs, dec_rt, dec_rd;
    logic [FUNC_W-1:0]    dec_func;
    logic                 dec_legal;
    logic                 transfer;
    logic                 drive_fields;

    assign transfer = instr_valid && instr_ready;

    // Decode the live word while IDLE so the address registers are already
    // valid in DECODE; afterwards decode the captured copy.
    assign dec_in = (state_q == IDLE) ? instr : instr_q;

    rtype_decoder u_decoder (
        .instr (dec_in),
        .rs    (dec_rs),
        .rt    (dec_rt),
        .rd    (dec_rd),
        .func  (dec_func),
        .legal (dec_legal)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        zero_d       = zero_q;
        drive_fields = 1'b0;
        we_d         = 1'b0;
        done_d       = 1'b0;
        illegal_d    = 1'b0;
        zf_d         = zero_flag;
        cnt_d        = retired_count;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d      = DECODE;
                    instr_d      = instr;
                    drive_fields = 1'b1;
                end
            end
            DECODE: begin
                if (dec_legal) begin
                    state_d      = EXEC;
                    drive_fields = 1'b1;
                end else begin
                    state_d   = IDLE;
                    illegal_d = 1'b1;
                end
            end
            EXEC: begin
                state_d      = WB;
                drive_fields = 1'b1;
                zero_d       = alu_zero;
                we_d         = (dec_rd != '0);
                done_d       = 1'b1;
            end
            WB: begin
                state_d = IDLE;
                zf_d    = zero_q;
                cnt_d   = retired_count + COUNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
        ra1_d   = drive_fields ? dec_rs   : '0;
        ra2_d   = drive_fields ? dec_rt   : '0;
        wa_d    = drive_fields ? dec_rd   : '0;
        func_d  = drive_fields ? dec_func : '0;
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State and registered outputs; reset discards any in-flight instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            instr_q       <= '0;
            zero_q        <= 1'b0;
            instr_ready   <= 1'b1;
            busy          <= 1'b0;
            read_address1 <= '0;
            read_address2 <= '0;
            write_address <= '0;
            func          <= '0;
            write_enable  <= 1'b0;
            done          <= 1'b0;
            illegal       <= 1'b0;
            zero_flag     <= 1'b0;
            retired_count <= '0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            zero_q        <= zero_d;
            instr_ready   <= ready_d;
            busy          <= busy_d;
            read_address1 <= ra1_d;
            read_address2 <= ra2_d;
            write_address <= wa_d;
            func          <= func_d;
            write_enable  <= we_d;
            done          <= done_d;
            illegal       <= illegal_d;
            zero_flag     <= zf_d;
            retired_count <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rtype_sequencer.sv
// Scoreboard bench for rtype_sequencer (COUNT_W=2 so the counter wraps).
module tb_rtype_sequencer;

    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic [31:0]   instr = '0;
    logic          alu_zero = 1'b0;
    logic          instr_ready, write_enable, busy, done, zero_flag, illegal;
    logic [4:0]    read_address1, read_address2, write_address;
    logic [3:0]    func;
    logic [CW-1:0] retired_count;

    rtype_sequencer #(.COUNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .alu_zero      (alu_zero),
        .read_address1 (read_address1),
        .read_address2 (read_address2),
        .write_address (write_address),
        .func          (func),
        .write_enable  (write_enable),
        .busy          (busy),
        .done          (done),
        .zero_flag     (zero_flag),
        .illegal       (illegal),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ill;
        logic [4:0]  ra1, ra2, wa;
        logic [3:0]  fn;
        bit          we;
        logic [1:0]  cnt;
        bit          zf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   events = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input bit ill, input logic [4:0] ra1, input logic [4:0] ra2,
                        input logic [4:0] wa, input logic [3:0] fn, input bit we,
                        input logic [1:0] cnt, input bit zf);
        exp_t e;
        e.ill = ill; e.ra1 = ra1; e.ra2 = ra2; e.wa = wa;
        e.fn = fn; e.we = we; e.cnt = cnt; e.zf = zf;
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) chk("ready_timeout", 32'(instr_ready), 1);
    endtask

    // One transfer; the word is scrambled afterwards to prove it was captured
    task automatic send(input logic [31:0] word, input logic az);
        wait_ready();
        instr       = word;
        alu_zero    = az;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 32'hDEAD_BEEF;
    endtask

    // Monitor: pops one expectation per done/illegal pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && write_enable) chk("we_outside_wb", 32'(done), 1);
            if (rst_n && (done || illegal)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", 32'({done, illegal}), 0);
                end else begin
                    e = sb.pop_front();
                    events++;
                    chk("event_kind", 32'({done, illegal}), e.ill ? 32'd1 : 32'd2);
                    if (done) begin
                        chk("wb_ra1", 32'(read_address1), 32'(e.ra1));
                        chk("wb_ra2", 32'(read_address2), 32'(e.ra2));
                        chk("wb_wa", 32'(write_address), 32'(e.wa));
                        chk("wb_func", 32'(func), 32'(e.fn));
                        chk("wb_we", 32'(write_enable), 32'(e.we));
                        @(negedge clk);
                        chk("retired_count", 32'(retired_count), 32'(e.cnt));
                        chk("zero_flag", 32'(zero_flag), 32'(e.zf));
                        chk("done_one_cycle", 32'(done), 0);
                    end else begin
                        chk("ill_we", 32'(write_enable), 0);
                        chk("ill_count", 32'(retired_count), 32'(e.cnt));
                        chk("ill_zero_flag", 32'(zero_flag), 32'(e.zf));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b2b [5];
        time         t_prev, t_now;
        int          n;

        // Reset state
        #12;
        chk("rst_ready", 32'(instr_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", 32'({done, illegal, write_enable, zero_flag}), 0);
        chk("rst_addr_func", 32'({read_address1, read_address2, write_address, func}), 0);
        chk("rst_count", 32'(retired_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of WB of an add aborts it
        send(32'h0022_1820, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("midwb_we_before", 32'(write_enable), 1);
        rst_n = 1'b0;
        #1;
        chk("midwb_we_async", 32'(write_enable), 0);
        chk("midwb_busy", 32'(busy), 0);
        chk("midwb_count", 32'(retired_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midwb_ready", 32'(instr_ready), 1);

        // add $3,$1,$2 with cycle-level checks
        push(0, 5'd1, 5'd2, 5'd3, 4'd2, 1, 2'd1, 0);
        send(32'h0022_1820, 1'b0);
        chk("dec_busy", 32'(busy), 1);
        chk("dec_ready", 32'(instr_ready), 0);
        chk("dec_addrs", 32'({read_address1, read_address2, write_address}), 32'({5'd1, 5'd2, 5'd3}));
        chk("dec_we", 32'(write_enable), 0);
        @(posedge clk);
        #1;
        chk("exec_func", 32'(func), 2);
        chk("exec_wa", 32'(write_address), 3);
        chk("exec_done", 32'(done), 0);
        @(posedge clk);
        #1;
        chk("wb_latency_done", 32'(done), 1);
        chk("wb_latency_we", 32'(write_enable), 1);
        @(posedge clk);
        #1;
        chk("idle_addr_func", 32'({read_address1, read_address2, write_address, func}), 0);

        // sub $5,$4,$4 with alu_zero=1
        push(0, 5'd4, 5'd4, 5'd5, 4'd6, 1, 2'd2, 1);
        send(32'h0084_2822, 1'b1);

        // lw: illegal, zero_flag stays 1
        push(1, 5'd0, 5'd0, 5'd0, 4'd0, 0, 2'd2, 1);
        send(32'h8C22_0000, 1'b0);
        @(posedge clk);
        #1;
        chk("ill_pulse_timing", 32'({illegal, busy}), 32'd2);

        // xor (funct 0x26): illegal
        push(1, 5'd0, 5'd0, 5'd0, 4'd0, 0, 2'd2, 1);
        send(32'h0022_3026, 1'b0);

        // or $6,$1,$2 with alu_zero=0 clears zero_flag
        push(0, 5'd1, 5'd2, 5'd6, 4'd1, 1, 2'd3, 0);
        send(32'h0022_3025, 1'b0);

        // add $0,$1,$2: no write, still retires (count wraps 3 -> 0)
        push(0, 5'd1, 5'd2, 5'd0, 4'd2, 0, 2'd0, 0);
        send(32'h0022_0020, 1'b0);

        // Back-to-back with instr_valid held high
        b2b[0] = 32'h0109_3824;  // and  $7,$8,$9
        b2b[1] = 32'h016C_5027;  // nor  $10,$11,$12
        b2b[2] = 32'h01CF_682A;  // slt  $13,$14,$15
        b2b[3] = 32'h0232_8023;  // subu $16,$17,$18
        b2b[4] = 32'h03DD_F961;  // addu $31,$30,$29 with shamt=5
        push(0, 5'd8,  5'd9,  5'd7,  4'd0,  1, 2'd1, 0);
        push(0, 5'd11, 5'd12, 5'd10, 4'd12, 1, 2'd2, 0);
        push(0, 5'd14, 5'd15, 5'd13, 4'd7,  1, 2'd3, 0);
        push(0, 5'd17, 5'd18, 5'd16, 4'd6,  1, 2'd0, 0);
        push(0, 5'd30, 5'd29, 5'd31, 4'd2,  1, 2'd1, 0);
        wait_ready();
        alu_zero    = 1'b0;
        instr_valid = 1'b1;
        t_prev      = 0;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!instr_ready && n < 50) begin
                chk("b2b_ready_vs_busy", 32'(instr_ready), 32'(!busy));
                @(negedge clk);
                n++;
            end
            if (!instr_ready) chk("b2b_ready_timeout", 32'(instr_ready), 1);
            instr = b2b[i];
            @(posedge clk);
            t_now = $time;
            if (i > 0) chk("b2b_spacing", 32'((t_now - t_prev) / 10), 4);
            t_prev = t_now;
            #1;
            @(negedge clk);
        end
        instr_valid = 1'b0;

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("events_seen", 32'(events), 11);
        chk("queue_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
